fp8_operand_sequencer: RTL and testbench

Front-end stage for the 8-bit floating-point adder (FP8: sign[7], exponent[6:3] bias 7, mantissa[2:0]; exponent 15 reserved for Inf/NaN). It accepts two operands serially over a shared 8-bit bus and classifies them. It resolves special cases (zero, Inf, NaN) itself. For ordinary cases it swaps the operands so the larger magnitude comes first, computes the alignment shift, and issues the pair to the adder over a valid/ready handshake. It then captures the adder's sum and holds it until the consumer acknowledges it.

---
 rtl/fp8_pkg.sv | 44 ++++
 rtl/fp8_classify_swap.sv | 50 +++++
 rtl/fp8_operand_sequencer.sv | 141 ++++++++++++++
 tb/tb_fp8_operand_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp8_pkg.sv
// rtl/fp8_pkg.sv - FP8 field widths, special constants, sequencer states and classify helpers
package fp8_pkg;

    localparam int FP8_W   = 8;
    localparam int EXP_W   = 4;
    localparam int MANT_W  = 3;
    localparam int SHIFT_W = 3;

    localparam logic [EXP_W-1:0] EXP_BIAS    = 4'd7;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 4'd15;

    localparam logic [FP8_W-1:0] FP8_QNAN    = 8'h7F;
    localparam logic [FP8_W-1:0] FP8_POS_INF = 8'h78;
    localparam logic [FP8_W-1:0] FP8_NEG_INF = 8'hF8;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_ISSUE,
        S_WAIT,
        S_OUT
    } seq_state_t;

    function automatic logic [EXP_W-1:0] exp_of(input logic [FP8_W-1:0] x);
        return x[FP8_W-2:MANT_W];
    endfunction

    function automatic logic [MANT_W-1:0] mant_of(input logic [FP8_W-1:0] x);
        return x[MANT_W-1:0];
    endfunction

    function automatic logic is_zero(input logic [FP8_W-1:0] x);
        return (x[FP8_W-2:0] == '0);
    endfunction

    function automatic logic is_inf(input logic [FP8_W-1:0] x);
        return (exp_of(x) == EXP_SPECIAL) && (mant_of(x) == '0);
    endfunction

    function automatic logic is_nan(input logic [FP8_W-1:0] x);
        return (exp_of(x) == EXP_SPECIAL) && (mant_of(x) != '0);
    endfunction

endpackage

// File: rtl/fp8_classify_swap.sv
// rtl/fp8_classify_swap.sv - special-case resolution, magnitude swap and alignment shift
module fp8_classify_swap
    import fp8_pkg::*;
(
    input  logic [FP8_W-1:0]   op_a,
    input  logic [FP8_W-1:0]   op_b,
    output logic               bypass,
    output logic [FP8_W-1:0]   bypass_res,
    output logic [FP8_W-1:0]   big_op,
    output logic [FP8_W-1:0]   small_op,
    output logic [SHIFT_W-1:0] shift
);

    logic [EXP_W-1:0] exp_diff;

    // Special cases in priority order: NaN, Inf clash, single Inf, zero A, zero B
    always_comb begin
        bypass     = 1'b1;
        bypass_res = FP8_QNAN;
        if (is_nan(op_a) || is_nan(op_b)) begin
            bypass_res = FP8_QNAN;
        end else if (is_inf(op_a) && is_inf(op_b)) begin
            bypass_res = (op_a[FP8_W-1] == op_b[FP8_W-1]) ? op_a : FP8_QNAN;
        end else if (is_inf(op_a)) begin
            bypass_res = op_a[FP8_W-1] ? FP8_NEG_INF : FP8_POS_INF;
        end else if (is_inf(op_b)) begin
            bypass_res = op_b[FP8_W-1] ? FP8_NEG_INF : FP8_POS_INF;
        end else if (is_zero(op_a)) begin
            bypass_res = op_b;
        end else if (is_zero(op_b)) begin
            bypass_res = op_a;
        end else begin
            bypass = 1'b0;
        end
    end

    // Larger magnitude first (A wins a tie); shift is the exponent gap clamped to 7
    always_comb begin
        if (op_b[FP8_W-2:0] > op_a[FP8_W-2:0]) begin
            big_op   = op_b;
            small_op = op_a;
        end else begin
            big_op   = op_a;
            small_op = op_b;
        end
        exp_diff = exp_of(big_op) - exp_of(small_op);
        shift    = (exp_diff > 4'd7) ? 3'd7 : exp_diff[SHIFT_W-1:0];
    end

endmodule

// File: rtl/fp8_operand_sequencer.sv
// rtl/fp8_operand_sequencer.sv - serial operand capture, adder issue, timeout and result hold
module fp8_operand_sequencer
    import fp8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FP8_W-1:0]   in_data,
    input  logic               in_load,
    output logic               in_ready,
    output logic [FP8_W-1:0]   add_a,
    output logic [FP8_W-1:0]   add_b,
    output logic [SHIFT_W-1:0] add_shift,
    output logic               add_valid,
    input  logic               add_ready,
    input  logic [FP8_W-1:0]   add_sum,
    input  logic               add_sum_valid,
    output logic [FP8_W-1:0]   res_data,
    output logic               res_valid,
    output logic               res_err,
    input  logic               res_ack
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t           state;
    seq_state_t           state_nxt;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 timed_out;
    logic [FP8_W-1:0]     op_a_q;
    logic                 load_b;

    logic                 cls_bypass;
    logic [FP8_W-1:0]     cls_res;
    logic [FP8_W-1:0]     cls_big;
    logic [FP8_W-1:0]     cls_small;
    logic [SHIFT_W-1:0]   cls_shift;

    // B is classified straight off the bus so the decision lands on the load edge
    fp8_classify_swap u_classify_swap (
        .op_a       (op_a_q),
        .op_b       (in_data),
        .bypass     (cls_bypass),
        .bypass_res (cls_res),
        .big_op     (cls_big),
        .small_op   (cls_small),
        .shift      (cls_shift)
    );

    assign load_b    = (state == S_B) && in_load;
    assign timed_out = (wait_cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; handshake outputs decode straight from state so reset clears them at once
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        add_valid = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_A: begin
                in_ready = 1'b1;
                if (in_load) state_nxt = S_B;
            end
            S_B: begin
                in_ready = 1'b1;
                if (in_load) state_nxt = cls_bypass ? S_OUT : S_ISSUE;
            end
            S_ISSUE: begin
                add_valid = 1'b1;
                if (add_ready) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (add_sum_valid || timed_out) state_nxt = S_OUT;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ack) state_nxt = S_A;
            end
            default: state_nxt = S_A;
        endcase
    end

    // Operand A capture and the issued pair, held until the next non-bypass B load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            add_shift <= '0;
        end else begin
            if ((state == S_A) && in_load) op_a_q <= in_data;
            if (load_b && !cls_bypass) begin
                add_a     <= cls_big;
                add_b     <= cls_small;
                add_shift <= cls_shift;
            end
        end
    end

    // Wait counter: zeroed while issuing, counts S_WAIT cycles up to the last allowed one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == S_ISSUE) begin
            wait_cnt <= '0;
        end else if ((state == S_WAIT) && !timed_out) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // Result register: bypass value, adder sum, or forced error; a late sum beats the timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_data <= '0;
            res_err  <= 1'b0;
        end else if (load_b && cls_bypass) begin
            res_data <= cls_res;
            res_err  <= 1'b0;
        end else if (state == S_WAIT) begin
            if (add_sum_valid) begin
                res_data <= add_sum;
                res_err  <= 1'b0;
            end else if (timed_out) begin
                res_data <= FP8_QNAN;
                res_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp8_operand_sequencer.sv
// tb/tb_fp8_operand_sequencer.sv - randomized and directed self-checking bench for fp8_operand_sequencer
module tb_fp8_operand_sequencer;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_load;
    logic       in_ready;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [2:0] add_shift;
    logic       add_valid;
    logic       add_ready;
    logic [7:0] add_sum;
    logic       add_sum_valid;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_err;
    logic       res_ack;

    fp8_operand_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_load       (in_load),
        .in_ready      (in_ready),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_shift     (add_shift),
        .add_valid     (add_valid),
        .add_ready     (add_ready),
        .add_sum       (add_sum),
        .add_sum_valid (add_sum_valid),
        .res_data      (res_data),
        .res_valid     (res_valid),
        .res_err       (res_err),
        .res_ack       (res_ack)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       e_in_ready;
    logic       e_add_valid;
    logic       e_res_valid;
    logic       e_res_err;
    logic       e_ops_live;
    logic [7:0] e_add_a;
    logic [7:0] e_add_b;
    logic [2:0] e_shift;
    logic [7:0] e_res_data;

    localparam logic [7:0] SP_A   [3] = '{8'h7F, 8'h78, 8'hF8};
    localparam logic [7:0] SP_B   [3] = '{8'h38, 8'hF8, 8'h40};
    localparam logic [7:0] SP_RES [3] = '{8'h7F, 8'h7F, 8'hF8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: results from the FP8 special-value rules and plain integer magnitudes
    function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                   output bit byp, output logic [7:0] res,
                                   output logic [7:0] big, output logic [7:0] sml,
                                   output logic [2:0] sh);
        int ea, eb, ma, mb, d;
        bit nan_a, nan_b, inf_a, inf_b;
        ea = int'(a[6:3]); eb = int'(b[6:3]);
        ma = int'(a[2:0]); mb = int'(b[2:0]);
        nan_a = (ea == 15) && (ma != 0);
        nan_b = (eb == 15) && (mb != 0);
        inf_a = (ea == 15) && (ma == 0);
        inf_b = (eb == 15) && (mb == 0);
        byp = 1'b1; res = 8'h00; big = a; sml = b; sh = 3'd0;
        if (nan_a || nan_b)            res = 8'h7F;
        else if (inf_a && inf_b)       res = (a[7] == b[7]) ? a : 8'h7F;
        else if (inf_a)                res = a;
        else if (inf_b)                res = b;
        else if (int'(a[6:0]) == 0)    res = b;
        else if (int'(b[6:0]) == 0)    res = a;
        else begin
            byp = 1'b0;
            if (int'(b[6:0]) > int'(a[6:0])) begin
                big = b;
                sml = a;
            end
            d  = int'(big[6:3]) - int'(sml[6:3]);
            sh = (d > 7) ? 3'd7 : 3'(d);
        end
    endfunction

    function automatic logic [7:0] gen_op(input logic [7:0] other);
        logic [7:0] v;
        v = 8'($urandom);
        case ($urandom_range(0, 9))
            0: v = {v[7], 7'h00};
            1: v = {v[7], 7'h78};
            2: v = {v[7], 4'hF, 3'($urandom_range(1, 7))};
            3: v = {v[7], other[6:0]};
            default: ;
        endcase
        return v;
    endfunction

    task automatic reset_expect();
        e_in_ready  = 1'b1;
        e_add_valid = 1'b0;
        e_res_valid = 1'b0;
        e_res_err   = 1'b0;
        e_ops_live  = 1'b0;
        e_add_a     = 8'h00;
        e_add_b     = 8'h00;
        e_shift     = 3'd0;
        e_res_data  = 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of the DUT against the model expectation
    always @(negedge clk) begin
        chk("in_ready",  32'(in_ready),  32'(e_in_ready));
        chk("add_valid", 32'(add_valid), 32'(e_add_valid));
        chk("res_valid", 32'(res_valid), 32'(e_res_valid));
        if (e_ops_live) begin
            chk("add_a",     32'(add_a),     32'(e_add_a));
            chk("add_b",     32'(add_b),     32'(e_add_b));
            chk("add_shift", 32'(add_shift), 32'(e_shift));
        end
        if (e_res_valid) begin
            chk("res_data", 32'(res_data), 32'(e_res_data));
            chk("res_err",  32'(res_err),  32'(e_res_err));
        end
    end

    task automatic op_load(input logic [7:0] a, input logic [7:0] b,
                           input int idle_a, input int idle_b, output bit byp);
        logic [7:0] res, big, sml;
        logic [2:0] sh;
        repeat (idle_a) begin
            in_load = 1'b0; in_data = 8'($urandom);
            res_ack = 1'($urandom); add_sum_valid = 1'($urandom); add_sum = 8'($urandom);
            tick();
        end
        in_load = 1'b1; in_data = a;
        res_ack = 1'($urandom); add_sum_valid = 1'($urandom);
        tick();
        repeat (idle_b) begin
            in_load = 1'b0; in_data = 8'($urandom);
            res_ack = 1'($urandom); add_sum_valid = 1'($urandom);
            tick();
        end
        in_load = 1'b1; in_data = b;
        ref_op(a, b, byp, res, big, sml, sh);
        tick();
        in_load = 1'b0; res_ack = 1'b0; add_sum_valid = 1'b0;
        e_in_ready = 1'b0;
        if (byp) begin
            e_res_valid = 1'b1;
            e_res_data  = res;
            e_res_err   = 1'b0;
        end else begin
            e_add_valid = 1'b1;
            e_ops_live  = 1'b1;
            e_add_a     = big;
            e_add_b     = sml;
            e_shift     = sh;
        end
    endtask

    task automatic op_issue(input int stall);
        repeat (stall) begin
            add_ready = 1'b0;
            in_load = 1'($urandom); in_data = 8'($urandom);
            res_ack = 1'($urandom); add_sum_valid = 1'($urandom); add_sum = 8'($urandom);
            tick();
        end
        add_ready = 1'b1;
        tick();
        add_ready = 1'b0; in_load = 1'b0; res_ack = 1'b0; add_sum_valid = 1'b0;
        e_add_valid = 1'b0;
    endtask

    // k = S_WAIT cycle (1-based) carrying add_sum_valid; k > TO means no sum ever arrives
    task automatic op_wait(input int k, input logic [7:0] s);
        int n;
        n = (k > TO) ? TO : k - 1;
        repeat (n) begin
            add_sum_valid = 1'b0;
            in_load = 1'($urandom); in_data = 8'($urandom); res_ack = 1'($urandom);
            tick();
        end
        if (k <= TO) begin
            add_sum_valid = 1'b1; add_sum = s;
            tick();
            e_res_data = s;
            e_res_err  = 1'b0;
        end else begin
            e_res_data = 8'h7F;
            e_res_err  = 1'b1;
        end
        add_sum_valid = 1'b0; in_load = 1'b0; res_ack = 1'b0;
        e_res_valid = 1'b1;
    endtask

    task automatic op_out(input int hold);
        repeat (hold) begin
            res_ack = 1'b0;
            in_load = 1'($urandom); in_data = 8'($urandom);
            add_sum_valid = 1'($urandom); add_sum = 8'($urandom);
            tick();
        end
        res_ack = 1'b1; in_load = 1'b0; add_sum_valid = 1'b0;
        tick();
        res_ack = 1'b0;
        e_res_valid = 1'b0;
        e_in_ready  = 1'b1;
        e_ops_live  = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int ia, input int ib,
                          input int stall, input int k, input logic [7:0] s, input int hold);
        bit byp;
        op_load(a, b, ia, ib, byp);
        if (!byp) begin
            op_issue(stall);
            op_wait(k, s);
        end
        op_out(hold);
    endtask

    initial begin
        bit         byp;
        logic [7:0] r, bg, sm, a, b;
        logic [2:0] sh;

        rst = 1'b1; in_load = 1'b0; in_data = 8'h00; add_ready = 1'b0;
        add_sum = 8'h00; add_sum_valid = 1'b0; res_ack = 1'b0;
        reset_expect();

        // Pin the model with hand-computed cases
        ref_op(8'h38, 8'h40, byp, r, bg, sm, sh);
        chk("model_norm_bypass", 32'(byp), 32'd0);
        chk("model_norm_big",    32'(bg),  32'h40);
        chk("model_norm_small",  32'(sm),  32'h38);
        chk("model_norm_shift",  32'(sh),  32'd1);
        ref_op(8'h00, 8'h45, byp, r, bg, sm, sh);
        chk("model_zero_res", 32'(r), 32'h45);
        ref_op(8'h78, 8'hF8, byp, r, bg, sm, sh);
        chk("model_infclash_res", 32'(r), 32'h7F);
        ref_op(8'h08, 8'h70, byp, r, bg, sm, sh);
        chk("model_sat_shift", 32'(sh), 32'd7);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_add_valid", 32'(add_valid), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_add_a",     32'(add_a),     32'h00);
        chk("rst_res_data",  32'(res_data),  32'h00);
        chk("rst_res_err",   32'(res_err),   32'd0);

        // Normal add with swap
        op_load(8'h38, 8'h40, 0, 0, byp);
        chk("norm_add_valid", 32'(add_valid), 32'd1);
        chk("norm_add_a",     32'(add_a),     32'h40);
        chk("norm_add_b",     32'(add_b),     32'h38);
        chk("norm_shift",     32'(add_shift), 32'd1);
        op_issue(0);
        op_wait(1, 8'h44);
        chk("norm_res_data", 32'(res_data), 32'h44);
        chk("norm_res_err",  32'(res_err),  32'd0);
        op_out(3);

        // Zero bypass, then specials back-to-back
        op_load(8'h00, 8'h45, 0, 0, byp);
        chk("zero_res_valid", 32'(res_valid), 32'd1);
        chk("zero_res_data",  32'(res_data),  32'h45);
        op_out(1);
        for (int i = 0; i < 3; i++) begin
            op_load(SP_A[i], SP_B[i], 0, 0, byp);
            chk("special_res", 32'(res_data), 32'(SP_RES[i]));
            op_out(0);
        end

        // Backpressure then timeout
        op_load(8'h38, 8'h40, 1, 0, byp);
        op_issue(5);
        op_wait(TO + 1, 8'h00);
        chk("timeout_res_valid", 32'(res_valid), 32'd1);
        chk("timeout_res_data",  32'(res_data),  32'h7F);
        chk("timeout_res_err",   32'(res_err),   32'd1);
        op_out(2);

        // Sum on the very last wait cycle beats the timeout
        run_op(8'h41, 8'h3A, 0, 0, 0, TO, 8'h5C, 0);

        // Tie and shift saturation
        op_load(8'h38, 8'hB8, 0, 0, byp);
        chk("tie_add_a", 32'(add_a), 32'h38);
        op_issue(0); op_wait(2, 8'h00); op_out(0);
        op_load(8'h08, 8'h70, 0, 0, byp);
        chk("sat_add_a",  32'(add_a),     32'h70);
        chk("sat_shift",  32'(add_shift), 32'd7);
        op_issue(1); op_wait(3, 8'h70); op_out(0);

        // Asynchronous reset while waiting on the adder
        op_load(8'h38, 8'h40, 0, 0, byp);
        op_issue(0);
        repeat (3) tick();
        #1 rst = 1'b1;
        reset_expect();
        #1;
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        chk("arst_add_valid", 32'(add_valid), 32'd0);
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_add_a",     32'(add_a),     32'h00);
        chk("arst_res_err",   32'(res_err),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        add_sum_valid = 1'b1; add_sum = 8'h55;
        tick();
        add_sum_valid = 1'b0;
        tick();
        chk("post_rst_res_valid", 32'(res_valid), 32'd0);
        chk("post_rst_in_ready",  32'(in_ready),  32'd1);

        // Randomized operations against the model
        for (int i = 0; i < 80; i++) begin
            a = gen_op(8'($urandom));
            b = gen_op(a);
            run_op(a, b, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 4),
                   $urandom_range(1, TO + 2), 8'($urandom), $urandom_range(0, 3));
        end

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
